uart_tx_frame_controller: RTL

- Sequences one UART transmit frame per accepted byte: start bit, 5-8 data bits LSB first, optional parity bit, then 1 or 2 stop bits, on a single serial line.
- Bit timing comes from a runtime baud divisor combined with the oversampling rate (16 or 13).
- Frame format follows the team's UART configuration fields: data type, parity enable/type, parity error injection, stop bits and oversampling.
- Sits between the TX packet source (valid/ready byte stream) and the tx pin; the RX side checks its output.

---
 rtl/uart_tx_frame_controller.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_frame_controller.sv
// UART transmit frame sequencer: start bit, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Bit time is divisor x oversampling clocks; every frame setting is captured when the byte is accepted.
module uart_tx_frame_controller #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] txData,
  input  logic                  txValid,
  output logic                  txReady,
  input  logic [3:0]            cfgDataBits,
  input  logic                  cfgParityEnable,
  input  logic                  cfgParityType,
  input  logic                  cfgParityErrorInject,
  input  logic [1:0]            cfgStopBits,
  input  logic [4:0]            cfgOverSampling,
  input  logic [15:0]           cfgBaudDivisor,
  output logic                  tx,
  output logic                  busy,
  output logic                  frameDone
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [2:0]            lastBit_q;
  logic                  parEn_q, parBit_q, stop2_q;
  logic [4:0]            osLast_q;
  logic [15:0]           divLast_q;
  logic [15:0]           divCnt_q;
  logic [4:0]            tickCnt_q;
  logic [2:0]            bitCnt_q;
  logic                  tx_q, busy_q, ready_q, done_q;

  logic [2:0]            lastBit_d;
  logic [4:0]            osLast_d;
  logic [15:0]           divLast_d;
  logic [DATA_WIDTH-1:0] mask_d;
  logic                  parBit_d;
  logic                  bitEnd;
  logic [2:0]            nextBit;

  // Configuration as it will be latched: out-of-range values fall back to 8 bits / OS 16 / divisor 1.
  always_comb begin
    lastBit_d = (cfgDataBits >= 4'd5 && cfgDataBits <= 4'd8) ? 3'(cfgDataBits - 4'd1) : 3'd7;
    osLast_d  = (cfgOverSampling == 5'd13) ? 5'd12 : 5'd15;
    divLast_d = (cfgBaudDivisor == 16'd0) ? 16'd0 : cfgBaudDivisor - 16'd1;
    mask_d    = '0;
    for (int i = 0; i < DATA_WIDTH; i++) mask_d[i] = (i <= int'(lastBit_d));
    parBit_d  = (^(txData & mask_d)) ^ cfgParityType ^ cfgParityErrorInject;
  end

  assign bitEnd  = (divCnt_q == divLast_q) && (tickCnt_q == osLast_q);
  assign nextBit = bitCnt_q + 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      lastBit_q <= '0;
      parEn_q   <= 1'b0;
      parBit_q  <= 1'b0;
      stop2_q   <= 1'b0;
      osLast_q  <= '0;
      divLast_q <= '0;
      divCnt_q  <= '0;
      tickCnt_q <= '0;
      bitCnt_q  <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Both counters wrap to zero exactly at bitEnd, so they are clear whenever a state exits.
      if (state_q != IDLE) begin
        if (divCnt_q == divLast_q) begin
          divCnt_q  <= '0;
          tickCnt_q <= (tickCnt_q == osLast_q) ? 5'd0 : tickCnt_q + 5'd1;
        end else begin
          divCnt_q <= divCnt_q + 16'd1;
        end
      end
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (txValid && ready_q) begin
            data_q    <= txData;
            lastBit_q <= lastBit_d;
            parEn_q   <= cfgParityEnable;
            parBit_q  <= parBit_d;
            stop2_q   <= (cfgStopBits == 2'd2);
            osLast_q  <= osLast_d;
            divLast_q <= divLast_d;
            state_q   <= START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        START: if (bitEnd) begin
          state_q  <= DATA;
          tx_q     <= data_q[0];
          bitCnt_q <= '0;
        end
        DATA: if (bitEnd) begin
          if (bitCnt_q == lastBit_q) begin
            bitCnt_q <= '0;
            if (parEn_q) begin
              state_q <= PARITY;
              tx_q    <= parBit_q;
            end else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            bitCnt_q <= nextBit;
            tx_q     <= data_q[nextBit];
          end
        end
        PARITY: if (bitEnd) begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
        STOP: if (bitEnd) begin
          // bitCnt doubles as the stop-bit counter for the two-stop-bit case.
          if (stop2_q && bitCnt_q == 3'd0) begin
            bitCnt_q <= 3'd1;
          end else begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign txReady   = ready_q;
  assign frameDone = done_q;
endmodule
